// File: rtl/morse_scroll_display.sv
// Buffered Morse symbol player: a small FIFO feeds a timed FSM that scrolls
// dots, dashes and gaps across a row of active-low seven-segment digits.
module morse_scroll_display #(
  parameter int DIGITS      = 4,
  parameter int DEPTH       = 16,
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic                         i_Clock,
  input  logic                         i_Resetn,
  input  logic                         i_Clear,
  input  logic [1:0]                   i_SymIn,
  input  logic                         i_SymValid,
  output logic                         o_SymReady,
  output logic                         o_Busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count,
  output logic [7*DIGITS-1:0]          o_HEX
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(7 * UNIT_CYCLES);

  localparam logic [1:0] SYM_LGAP = 2'd0;
  localparam logic [1:0] SYM_DOT  = 2'd1;
  localparam logic [1:0] SYM_DASH = 2'd2;
  localparam logic [1:0] SYM_WGAP = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SPACE = 2'd2
  } state_t;

  logic [1:0]          r_mem [DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;
  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic [2*DIGITS-1:0] r_codes;
  logic                r_mark;

  logic                w_write;
  logic                w_pop;
  logic                w_flush;
  logic [1:0]          w_head;
  logic [2*DIGITS-1:0] w_shifted;

  assign w_flush    = !i_Resetn || i_Clear;
  assign o_SymReady = (r_count != CW'(DEPTH));
  assign o_Count    = r_count;
  assign o_Busy     = (r_state != IDLE);
  assign w_write    = i_SymValid && o_SymReady && !i_Clear;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rdPtr];

  // Newest symbol enters digit 0; the oldest code falls off the far end.
  generate
    if (DIGITS == 1) begin : g_shiftOne
      assign w_shifted = w_head;
    end else begin : g_shiftMany
      assign w_shifted = {r_codes[2*DIGITS-3:0], w_head};
    end
  endgenerate

  function automatic logic [TW-1:0] holdLoad(input logic [1:0] sym);
    case (sym)
      SYM_DOT:  return TW'(UNIT_CYCLES - 1);
      SYM_WGAP: return TW'(7 * UNIT_CYCLES - 1);
      default:  return TW'(3 * UNIT_CYCLES - 1);
    endcase
  endfunction

  always_ff @(posedge i_Clock) begin
    if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wrPtr] <= i_SymIn;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Timer is loaded with duration-1 so each phase lasts exactly its length.
  always_ff @(posedge i_Clock) begin
    if (w_flush) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_codes <= '0;
      r_mark  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_codes <= w_shifted;
            r_timer <= holdLoad(w_head);
            r_mark  <= (w_head == SYM_DOT) || (w_head == SYM_DASH);
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_timer == '0) begin
            if (r_mark) begin
              r_timer <= TW'(UNIT_CYCLES - 1);
              r_state <= SPACE;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        SPACE: begin
          if (r_timer == '0) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Digit 0 goes dark during the inter-element space, even with one digit.
  always_comb begin
    o_HEX = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!(k == 0 && r_state == SPACE)) begin
        case (r_codes[2*k +: 2])
          SYM_DOT:  o_HEX[7*k +: 7] = 7'b1111110;
          SYM_DASH: o_HEX[7*k +: 7] = 7'b0111110;
          default:  o_HEX[7*k +: 7] = 7'b1111111;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_scroll_display.sv
// Randomized bench for morse_scroll_display, checked every cycle against a
// schedule-based model (symbol queue, display list, and busy/space windows).
module tb_morse_scroll_display;

  localparam int DIGITS      = 4;
  localparam int DEPTH       = 4;
  localparam int UNIT_CYCLES = 4;
  localparam int CW          = $clog2(DEPTH + 1);
  localparam int CYCLES      = 4000;

  logic              clock = 1'b0;
  logic              resetn;
  logic              clear;
  logic [1:0]        symIn;
  logic              symValid;
  logic              symReady;
  logic              busy;
  logic [CW-1:0]     count;
  logic [7*DIGITS-1:0] hex;

  int checkCount = 0;
  int errorCount = 0;

  // Model state: edge numbers at which the current symbol's phases end.
  logic [1:0] modelQ[$];
  int         modelDisp [DIGITS];
  int         edgeNum  = 0;
  int         idleEdge = 0;
  int         holdEnd  = 0;
  bit         modelMark = 1'b0;

  morse_scroll_display #(
    .DIGITS(DIGITS),
    .DEPTH(DEPTH),
    .UNIT_CYCLES(UNIT_CYCLES)
  ) dut (
    .i_Clock(clock),
    .i_Resetn(resetn),
    .i_Clear(clear),
    .i_SymIn(symIn),
    .i_SymValid(symValid),
    .o_SymReady(symReady),
    .o_Busy(busy),
    .o_Count(count),
    .o_HEX(hex)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic rn, input logic cl, input logic v, input logic [1:0] s);
    resetn   = rn;
    clear    = cl;
    symValid = v;
    symIn    = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edgeNum, observed, expected);
    end
  endtask

  function automatic int symUnits(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd3:    return 7;
      default: return 3;
    endcase
  endfunction

  function automatic logic [6:0] segFor(input int code);
    if (code == 1) return 7'b1111110;
    if (code == 2) return 7'b0111110;
    return 7'b1111111;
  endfunction

  // One clock edge of the reference behaviour, using pre-edge queue contents.
  task automatic modelStep(input logic rn, input logic cl, input logic v, input logic [1:0] s);
    int preCount;
    bit canPop;
    bit canWrite;
    logic [1:0] popped;
    edgeNum++;
    if (!rn || cl) begin
      modelQ.delete();
      for (int k = 0; k < DIGITS; k++) modelDisp[k] = 0;
      idleEdge  = edgeNum;
      holdEnd   = edgeNum;
      modelMark = 1'b0;
    end else begin
      preCount = modelQ.size();
      canPop   = (idleEdge < edgeNum) && (preCount > 0);
      canWrite = v && (preCount < DEPTH);
      if (canPop) begin
        popped = modelQ.pop_front();
        for (int k = DIGITS - 1; k > 0; k--) modelDisp[k] = modelDisp[k-1];
        modelDisp[0] = int'(popped);
        modelMark = (popped == 2'd1) || (popped == 2'd2);
        holdEnd   = edgeNum + symUnits(popped) * UNIT_CYCLES;
        idleEdge  = holdEnd + (modelMark ? UNIT_CYCLES : 0);
      end
      if (canWrite) modelQ.push_back(s);
    end
  endtask

  function automatic logic [7*DIGITS-1:0] expectedHex();
    logic [7*DIGITS-1:0] h;
    bit inSpace;
    inSpace = modelMark && (edgeNum >= holdEnd) && (edgeNum < idleEdge);
    for (int k = 0; k < DIGITS; k++) begin
      h[7*k +: 7] = (k == 0 && inSpace) ? 7'b1111111 : segFor(modelDisp[k]);
    end
    return h;
  endfunction

  task automatic runCycle(input logic rn, input logic cl, input logic v, input logic [1:0] s);
    applyStimulus(rn, cl, v, s);
    @(posedge clock);
    modelStep(rn, cl, v, s);
    @(negedge clock);
    checkOutput("hex", 32'(hex), 32'(expectedHex()));
    checkOutput("busy", 32'(busy), 32'(edgeNum < idleEdge));
    checkOutput("count", 32'(count), 32'(modelQ.size()));
    checkOutput("symReady", 32'(symReady), 32'(modelQ.size() < DEPTH));
  endtask

  initial begin
    bit burst;
    logic rn;
    logic cl;
    logic v;
    for (int k = 0; k < DIGITS; k++) modelDisp[k] = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    runCycle(1'b0, 1'b0, 1'b0, 2'd0);
    runCycle(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) runCycle(1'b1, 1'b0, 1'b0, 2'd0);
    burst = 1'b1;
    for (int i = 0; i < CYCLES; i++) begin
      if (i % 400 == 0) burst = ~burst;
      rn = ($urandom_range(0, 299) != 0);
      cl = !rn || ($urandom_range(0, 149) == 0);
      v  = !rn || (burst ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0));
      runCycle(rn, cl, v, 2'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/morse_scroll_display.md
# morse_scroll_display

Buffered, timed Morse symbol player for the board's seven-segment displays. Upstream logic (switch decoder or text-to-Morse encoder) pushes 2-bit Morse symbols into an internal FIFO. The block pops them one at a time, shifts each into a DIGITS-wide scrolling display, and holds it for its standard Morse duration. It is the parametrised, timed, multi-digit successor to the single-digit dash/dot decoder.

## Interface
- DIGITS, 4: number of seven-segment digits driven; must be at least 1.
- DEPTH, 16: symbol FIFO depth; must be a power of two and at least 2.
- UNIT_CYCLES, 12500000: clock cycles per Morse time unit (0.25 s at 50 MHz); must be at least 1.
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  reset; synchronous, active-low.
- Clear  in  1  synchronous flush, active-high. Resetn low has priority over Clear.
- SymIn  in  2  symbol code: 0 = letter gap, 1 = dot, 2 = dash, 3 = word gap.
- SymValid  in  1  SymIn is valid this cycle.
- SymReady  out  1  FIFO can accept a symbol; equals !Full.
- Busy  out  1  a symbol is being played (FSM not in IDLE).
- Count  out  $clog2(DEPTH+1)  symbols currently queued.
- HEX  out  7*DIGITS  active-low segments. Digit k, segment s (a=0 … g=6) is at HEX[7k+s]. Digit 0 is the newest symbol.

## Operation
- Segment patterns:
  - Blank: all segments off.
  - Dot: segment 0 lit only.
  - Dash: segments 0 and 6 lit.
  - Letter gap and word gap both display as blank.
- Symbol durations, D, in units: dot 1, dash 3, letter gap 3, word gap 7.
- FIFO:
  - A write occurs when SymValid && SymReady.
  - A pop occurs only from IDLE when Count != 0 (registered Count).
  - A write and a pop may happen in the same cycle; Count is then unchanged.
  - Writes while full are not possible, because SymReady is low.
  - Read and write pointers wrap modulo DEPTH.
- Display register: DIGITS 2-bit codes. On a pop, code[k] <= code[k-1] for k >= 1, and code[0] <= the popped symbol. The oldest code is discarded.
- FSM states: IDLE, HOLD, SPACE.
  - IDLE: if Count != 0, pop, shift, load the timer with D*UNIT_CYCLES-1, go to HOLD. Otherwise stay.
  - HOLD: decrement the timer. At 0:
    - if the symbol was a dot or dash, load UNIT_CYCLES-1 and go to SPACE;
    - otherwise go to IDLE.
  - SPACE: digit 0 is forced blank (the other digits are unchanged); decrement the timer; at 0 go to IDLE.
- Timer width is $clog2(7*UNIT_CYCLES) bits. It counts down only.
- Clear: FIFO emptied, Count=0, all codes set to letter gap, FSM to IDLE, timer=0. A write presented in the same cycle is dropped.
- Reset values: HEX all ones, Busy 0, Count 0, SymReady 1, FSM IDLE, all codes letter gap.

## Timing
- A write at edge t makes Count=1 after t.
  - If the FSM is in IDLE, the pop happens at edge t+1.
  - The new code appears on HEX after edge t+1.
- HOLD lasts exactly D*UNIT_CYCLES cycles. SPACE lasts exactly UNIT_CYCLES cycles.
- After SPACE ends (or HOLD ends, for gap symbols), the FSM spends 1 cycle in IDLE before the next pop.
  - Total dot/dash period = 1 + (D+1)*UNIT_CYCLES cycles.
  - Total gap period = 1 + D*UNIT_CYCLES cycles.
- Busy rises at the pop edge and falls at the edge that enters IDLE.
- SymReady and Count are derived from registered state: no combinational path from SymValid to SymReady.
- Clear or reset in mid-HOLD or mid-SPACE takes effect at that edge. The next cycle shows the reset values.
- A dot/dash with DIGITS=1 is still blanked during its SPACE.

## Test plan
Parameters for all scenarios: DIGITS=4, DEPTH=4, UNIT_CYCLES=4.
- Reset, then idle 10 cycles -> HEX=28'hFFFFFFF, Busy=0, Count=0, SymReady=1.
- Push a dot at edge 0 -> pop at edge 1; Busy=1, HEX[6:0]=7'b1111110 for cycles 1-4 after the pop, blank for cycles 5-8; Busy=0 after edge 9; next pop possible at edge 10.
- Push dash, dot, word gap back-to-back ->
  - dash held 12 cycles then 4 blank;
  - dot shifts the dash to digit 1 (HEX[13:7]=7'b0111110);
  - the word gap holds 28 cycles with no SPACE;
  - the final display has the dash in digit 2 and the dot in digit 1.
- Push 5 symbols with SymValid held high while the FSM is busy -> 4 accepted, Count=4, SymReady=0; the fifth is retained only after a pop frees a slot.
- Assert Clear in the middle of a dash HOLD with Count=2 -> the next cycle shows HEX all ones, Count=0, Busy=0, SymReady=1.
- Assert Resetn=0 together with Clear=1 and SymValid=1 -> state equals the reset values; the symbol is not stored.
